// File: rtl/oam_dma.sv
// Sprite DMA engine: on a CPU write to DMA_REG_ADDR, stalls the CPU and copies
// one 256-byte page from memory to the OAM data port, then returns the bus.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_write,
    input  logic [7:0]  bus_din,
    output logic        cpu_ready,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_write,
    output logic        dma_active
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0] state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;
    logic       trigger;

    assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            page   <= '0;
            idx    <= '0;
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_dout;
                        idx   <= '0;
                        state <= HALT;
                    end
                end
                // An odd HALT cycle costs one extra ALIGN cycle before reading.
                HALT:    state <= parity ? ALIGN : READ;
                ALIGN:   state <= READ;
                READ:    state <= WRITE;
                WRITE: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces the idle pass-through view immediately, not at the next edge.
    always_comb begin
        bus_addr   = cpu_addr;
        bus_dout   = cpu_dout;
        bus_write  = cpu_write;
        cpu_ready  = 1'b1;
        dma_active = 1'b0;
        if (!reset) begin
            case (state)
                HALT, ALIGN: begin
                    bus_write  = 1'b0;
                    cpu_ready  = 1'b0;
                    dma_active = 1'b1;
                end
                READ: begin
                    bus_addr   = {page, idx};
                    bus_write  = 1'b0;
                    cpu_ready  = 1'b0;
                    dma_active = 1'b1;
                end
                WRITE: begin
                    bus_addr   = OAM_DATA_ADDR;
                    bus_dout   = bus_din;
                    bus_write  = 1'b1;
                    cpu_ready  = 1'b0;
                    dma_active = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected bus writes, DMA read
// addresses and stall lengths; a negedge monitor pops and compares them.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_write;
    logic [7:0]  bus_din;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_write;
    logic        dma_active;

    localparam logic [15:0] IDLE_ADDR = 16'h8123;

    oam_dma #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_write(cpu_write), .bus_din(bus_din), .cpu_ready(cpu_ready),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_write(bus_write),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    logic [23:0] wq[$];
    logic [15:0] rq[$];
    int          sq[$];
    int          stall = 0;
    int          pcount = 0;
    int          checks = 0;
    int          errors = 0;

    // Memory with one cycle of read latency.
    always @(posedge clk) bus_din <= mem[bus_addr];

    // Cycles since reset released; its LSB is the free-running parity.
    always @(posedge clk) pcount <= reset ? 0 : pcount + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] ew;
        logic [15:0] er;
        if (reset) begin
            chk("reset_ready", cpu_ready, 1);
            chk("reset_active", dma_active, 0);
            chk("reset_pass", {bus_addr, bus_write}, {cpu_addr, cpu_write});
        end
        chk("active_vs_ready", dma_active, !cpu_ready);
        if (cpu_ready)
            chk("idle_pass", {bus_addr, bus_dout, bus_write}, {cpu_addr, cpu_dout, cpu_write});
        if (bus_write) begin
            if (wq.size() == 0) chk("unexpected_write", {bus_addr, bus_dout}, 0);
            else begin
                ew = wq.pop_front();
                chk("bus_write", {bus_addr, bus_dout}, ew);
            end
        end
        if (!cpu_ready && !bus_write && bus_addr != cpu_addr) begin
            if (rq.size() == 0) chk("unexpected_read", bus_addr, 0);
            else begin
                er = rq.pop_front();
                chk("read_addr", bus_addr, er);
            end
        end
        if (!cpu_ready) stall++;
        else if (stall != 0) begin
            if (sq.size() == 0) chk("unexpected_stall", stall, 0);
            else chk("stall_len", stall, sq.pop_front());
            stall = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr = IDLE_ADDR; cpu_dout = 8'h00; cpu_write = 1'b0;
    endtask

    // want_align: -1 any, 0/1 forces HALT parity. abort_at: -1 full, else the
    // idx whose WRITE cycle gets reset. retrig keeps a $4014 write up in HALT.
    task automatic dma_trigger(input logic [7:0] pg, input int want_align,
                               input int abort_at, input bit retrig);
        int a;
        int n;
        if (want_align >= 0 && ((pcount % 2 == 0) ? 1 : 0) != want_align) step();
        a = (pcount % 2 == 0) ? 1 : 0;
        cpu_addr = 16'h4014; cpu_dout = pg; cpu_write = 1'b1;
        wq.push_back({16'h4014, pg});
        n = (abort_at < 0) ? 256 : abort_at;
        for (int i = 0; i < n; i++) begin
            rq.push_back({pg, 8'(i)});
            wq.push_back({16'h2004, mem[{pg, 8'(i)}]});
        end
        if (abort_at >= 0) begin
            rq.push_back({pg, 8'(abort_at)});
            sq.push_back(2 * abort_at + 2 + a);
        end else sq.push_back(513 + a);
        step();
        cpu_idle();
        if (retrig) begin
            cpu_addr = 16'h4014; cpu_dout = 8'h77; cpu_write = 1'b1;
        end
        @(negedge clk);
        chk("ready_fall", cpu_ready, 0);
        if (abort_at >= 0) begin
            repeat (2 + a + 2 * abort_at) step();
            reset = 1'b1;
            @(negedge clk);
            chk("abort_ready", cpu_ready, 1);
            chk("abort_active", dma_active, 0);
            step();
            reset = 1'b0;
            @(negedge clk);
            chk("post_abort_active", dma_active, 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        step();
        cpu_idle();
        while ((wq.size() != 0 || rq.size() != 0 || sq.size() != 0 || stall != 0) && t < 1200) begin
            step();
            t++;
        end
        chk("drain_timeout", t < 1200, 1);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
    endtask

    task automatic cpu_wr(input logic [15:0] ad, input logic [7:0] d);
        cpu_addr = ad; cpu_dout = d; cpu_write = 1'b1;
        wq.push_back({ad, d});
        @(negedge clk);
        chk("nontrig_ready", cpu_ready, 1);
        chk("nontrig_active", dma_active, 0);
        step();
        cpu_idle();
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        reset = 1'b1;
        cpu_idle();
        step(); step();
        reset = 1'b0;
        repeat (3) step();

        dma_trigger(8'h02, 0, -1, 1'b0);
        drain();
        dma_trigger(8'h02, 1, -1, 1'b0);
        drain();
        dma_trigger(8'hFF, -1, -1, 1'b0);
        drain();

        cpu_wr(16'h4013, 8'h55);
        cpu_wr(16'h4015, 8'h55);
        cpu_addr = 16'h4014; cpu_dout = 8'h55; cpu_write = 1'b0;
        @(negedge clk);
        chk("read4014_ready", cpu_ready, 1);
        step();
        cpu_idle();
        repeat (3) begin
            @(negedge clk);
            chk("nontrig_quiet", dma_active, 0);
            step();
        end

        dma_trigger(8'h05, -1, 64, 1'b0);
        drain();
        dma_trigger(8'h03, -1, -1, 1'b0);
        drain();

        dma_trigger(8'h11, -1, -1, 1'b1);
        repeat (20) step();
        cpu_addr = 16'h4014; cpu_dout = 8'h22; cpu_write = 1'b1;
        repeat (5) step();
        cpu_idle();
        drain();

        repeat (5) begin
            repeat ($urandom_range(0, 4)) begin
                ra = 16'($urandom);
                if (ra == 16'h4014) ra = 16'h4016;
                cpu_wr(ra, 8'($urandom));
            end
            pg = 8'($urandom);
            if (pg == 8'h81) pg = 8'h80;
            dma_trigger(pg, -1, -1, 1'b0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA engine between the `cpu` core and the system memory bus. A CPU write to `$4014` stalls the CPU through its `ready` input. The engine then copies one 256-byte page from memory to the PPU OAM data port at `$2004`, and finally hands the bus back to the CPU. When idle, it passes the CPU's bus signals through unchanged.

## Interface
Parameters:
- `DMA_REG_ADDR`, default `16'h4014`: CPU write address that triggers a transfer.
- `OAM_DATA_ADDR`, default `16'h2004`: destination address for every DMA write.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cpu_addr`  in  16  CPU address output.
- `cpu_dout`  in  8  CPU write data.
- `cpu_write`  in  1  CPU write strobe.
- `bus_din`  in  8  memory read data; registered, valid the cycle after the address is presented.
- `cpu_ready`  out  1  drives CPU `ready`; 0 stalls the CPU.
- `bus_addr`  out  16  memory bus address.
- `bus_dout`  out  8  memory bus write data.
- `bus_write`  out  1  memory bus write strobe.
- `dma_active`  out  1  high whenever state ≠ IDLE.

## Operation
- Registers:
  - `state` ∈ {IDLE, HALT, ALIGN, READ, WRITE}.
  - `page[7:0]`.
  - `idx[7:0]`.
  - `parity` (1 bit; toggles every clk; reset 0).
- IDLE:
  - Pass-through: `bus_addr=cpu_addr`, `bus_dout=cpu_dout`, `bus_write=cpu_write`, `cpu_ready=1`.
  - Trigger when `cpu_write && cpu_addr==DMA_REG_ADDR`:
    - Latch `page<=cpu_dout` and `idx<=0`; next state is HALT.
    - The trigger write itself still passes through to the bus.
  - Reads of `DMA_REG_ADDR` do not trigger.
- HALT:
  - `cpu_ready=0`, `bus_addr=cpu_addr`, `bus_write=0`.
  - Next state: ALIGN if `parity==1` this cycle, else READ.
- ALIGN: same outputs as HALT; next state READ.
- READ: `bus_addr={page,idx}`, `bus_write=0`, `cpu_ready=0`; next state WRITE.
- WRITE:
  - `bus_addr=OAM_DATA_ADDR`, `bus_dout=bus_din` (combinational pass-through of the data fetched in READ), `bus_write=1`, `cpu_ready=0`.
  - `idx<=idx+1` (8-bit, wraps).
  - If `idx==8'hFF`, next state is IDLE; otherwise READ.
- Source address never carries into the page byte: page `$FF` reads `$FF00–$FFFF`.
- Outside IDLE:
  - CPU writes are suppressed from the bus.
  - `$4014` writes are ignored; `page` is not overwritten.
- `dma_active = (state != IDLE)`.
- Reset (any cycle, including mid-transfer):
  - While `reset` is high, outputs take IDLE values combinationally: `cpu_ready=1`, `dma_active=0`, `bus_write=cpu_write`, pass-through.
  - At the clock edge: `state<=IDLE`, `idx<=0`, `page<=0`, `parity<=0`.
  - No partial-transfer resume; the next trigger restarts at `idx 0`.

## Timing
- Trigger write occurs in cycle T.
  - `cpu_ready` falls in T+1 (HALT).
  - First READ is in T+2, or T+3 if ALIGN was taken.
- READ/WRITE pairs are strictly alternating with no gaps: 256 pairs = 512 cycles.
- Stall length (cycles with `cpu_ready=0`) is exactly 513 (even parity in HALT) or 514 (odd).
- `cpu_ready` returns to 1 in the cycle after the final WRITE (`idx $FF`); pass-through resumes in that same cycle.
- A new trigger is accepted in the first IDLE cycle after completion.
- Memory latency is exactly 1 cycle: the data for READ address k appears on `bus_din` in the following WRITE cycle.
- `parity` is free-running from reset, independent of DMA activity.

## Test plan
- Page `$02` transfer, HALT parity 0:
  - Stimulus: memory[`$0200+i`]=`i^$A5`; CPU writes `$02` to `$4014`.
  - Required:
    - `cpu_ready` low for exactly 513 cycles.
    - 256 READs at `$0200..$02FF` in order.
    - 256 writes to `$2004` with data `i^$A5`.
    - Bus returns to pass-through afterwards.
- Same transfer, HALT parity 1 (trigger issued one cycle later): exactly 514 stall cycles; one ALIGN cycle with `bus_write=0` precedes the first READ.
- Page `$FF` transfer: source addresses `$FF00..$FFFF`, no wrap into `$0000`; last write data = memory[`$FFFF`].
- Non-trigger traffic: CPU writes `$55` to `$4013` and `$4015`, and reads `$4014`. Required: no DMA; `cpu_ready` stays 1; bus mirrors the CPU each cycle.
- Reset mid-transfer:
  - Stimulus: assert `reset` for 1 cycle during the WRITE of `idx $40`.
  - Required: `cpu_ready=1` and `dma_active=0` in that cycle and after.
  - A subsequent `$4014` write of `$03` performs a full transfer starting at `$0300`.
- Retrigger: a `$4014` write (via forced `cpu_write`) during an active transfer is ignored; the source page is unchanged through `idx $FF`.
